// File: rtl/ex_1_sweep_ctrl_pkg.sv
// rtl/ex_1_sweep_ctrl_pkg.sv - shared widths, golden table and state encoding for the ex_1 sweep
package ex_1_sweep_ctrl_pkg;

  localparam int unsigned EX1_VEC_W  = 4;
  localparam logic [15:0] EX1_GOLDEN = 16'h1133;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/ex_1_first_mismatch.sv
// rtl/ex_1_first_mismatch.sv - 16-to-4 lowest-set-bit priority encoder with an all-clear flag
module ex_1_first_mismatch (
  input  logic [15:0] diff,
  output logic [3:0]  idx,
  output logic        none
);

  always_comb begin
    idx  = '0;
    none = (diff == 16'd0);
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ex_1_sweep_ctrl.sv
// rtl/ex_1_sweep_ctrl.sv - clocked 16-vector self-test sweep of the ex_1 gate network
module ex_1_sweep_ctrl
  import ex_1_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = EX1_GOLDEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 y,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [EX1_VEC_W-1:0] fail_idx,
  output logic [15:0]          table_out
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  sweep_state_e         state_q, state_d;
  logic [EX1_VEC_W-1:0] vec_q, vec_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [15:0]          table_q, table_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [EX1_VEC_W-1:0] fail_idx_q, fail_idx_d;

  logic [15:0]          table_sampled;
  logic [15:0]          mismatch;
  logic [3:0]           mm_idx;
  logic                 mm_none;

  // Table as it will look once the current vector's y is folded in, so the
  // verdict on the last vector is ready in the same cycle as done.
  always_comb begin
    table_sampled        = table_q;
    table_sampled[vec_q] = y;
  end

  assign mismatch = table_sampled ^ GOLDEN;

  ex_1_first_mismatch u_first_mismatch (
    .diff (mismatch),
    .idx  (mm_idx),
    .none (mm_none)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    table_d    = table_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_HOLD;
          vec_d      = '0;
          cnt_d      = '0;
          table_d    = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d    = ST_IDLE;
          vec_d      = '0;
          cnt_d      = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          table_d = table_sampled;
          cnt_d   = '0;
          if (vec_q == 4'd15) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            pass_d     = mm_none;
            fail_idx_d = mm_none ? 4'd0 : mm_idx;
          end else begin
            vec_d  = vec_q + 4'd1;
            busy_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 4'd1;
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      table_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      table_q    <= table_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_idx     = fail_idx_q;
  assign table_out    = table_q;

endmodule
